hazard_stall_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage RISC-V core. Generates the write and flush enables for PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three sources:
- load-use hazards
- taken branches/jumps resolved in EX
- a multi-cycle data memory with a ready handshake

Adds a memory-wait timeout with a sticky error state, plus stall and flush performance counters.

---
 rtl/core_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_ctrl_if.sv | 47 ++++
 rtl/hazard_detect.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control blocks.
//   ctrl_state_e : sequencing controller states (RUN, MEM_WAIT, ERROR)
//   REG_ZERO     : architectural x0, never a real data dependency
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath and the sequencing controller.
//   Pipeline -> controller : MemRead_EX, RD_EX, RS1_ID, RS2_ID, uses_rs1_ID,
//                            uses_rs2_ID, branch_taken_EX, mem_req_MEM, mem_ready
//   Controller -> pipeline : PC_write, IF_ID_write, IF_ID_flush, ID_EX_write,
//                            ID_EX_flush, EX_MEM_write, MEM_WB_write,
//                            mem_timeout_err, stall_cnt, flush_cnt
// master = pipeline side, slave = controller side.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             MemRead_EX;
  logic [4:0]       RD_EX;
  logic [4:0]       RS1_ID;
  logic [4:0]       RS2_ID;
  logic             uses_rs1_ID;
  logic             uses_rs2_ID;
  logic             branch_taken_EX;
  logic             mem_req_MEM;
  logic             mem_ready;

  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_write;
  logic             ID_EX_flush;
  logic             EX_MEM_write;
  logic             MEM_WB_write;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output MemRead_EX, RD_EX, RS1_ID, RS2_ID, uses_rs1_ID, uses_rs2_ID,
           branch_taken_EX, mem_req_MEM, mem_ready,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, MEM_WB_write, mem_timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  MemRead_EX, RD_EX, RS1_ID, RS2_ID, uses_rs1_ID, uses_rs2_ID,
           branch_taken_EX, mem_req_MEM, mem_ready,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
           EX_MEM_write, MEM_WB_write, mem_timeout_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the instruction in ID reads a register
// that the load currently in EX has not produced yet.
//   MemRead_EX, RD_EX            : load in EX and its destination
//   RS1_ID/RS2_ID, uses_rs*_ID   : ID source registers and whether they are read
//   load_use                     : ID must wait one cycle behind the load
module hazard_detect
  import core_ctrl_pkg::*;
(
  input  logic       MemRead_EX,
  input  logic [4:0] RD_EX,
  input  logic [4:0] RS1_ID,
  input  logic [4:0] RS2_ID,
  input  logic       uses_rs1_ID,
  input  logic       uses_rs2_ID,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = uses_rs1_ID && (RS1_ID == RD_EX);
  assign rs2_hit  = uses_rs2_ID && (RS2_ID == RD_EX);
  // x0 always reads zero, so a load targeting it creates no dependency.
  assign load_use = MemRead_EX && (RD_EX != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_stall_ctrl_if.slave -- hazard inputs, stage write/flush
//                enables, sticky memory timeout error, stall/flush counters
// Enables are combinational from the registered state and current inputs.
// Priority: memory miss freeze > taken branch flush > load-use stall.
module hazard_stall_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] ST_ERROR    = ERROR;
  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  logic [1:0]       state;
  logic [7:0]       wait_cnt;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic load_use;
  logic mem_miss;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  hazard_detect u_hazard_detect (
    .MemRead_EX  (bus.MemRead_EX),
    .RD_EX       (bus.RD_EX),
    .RS1_ID      (bus.RS1_ID),
    .RS2_ID      (bus.RS2_ID),
    .uses_rs1_ID (bus.uses_rs1_ID),
    .uses_rs2_ID (bus.uses_rs2_ID),
    .load_use    (load_use)
  );

  // A request answered in the same cycle is not a miss.
  assign mem_miss = bus.mem_req_MEM && !bus.mem_ready;

  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    exmem_w = 1'b1;
    memwb_w = 1'b1;
    if (reset) begin
      // free-running defaults while reset is held
    end else if (state == ST_ERROR) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_w = 1'b0;
    end else if (mem_miss) begin
      // Full freeze; the MEM_WB hold just repeats the retired instruction.
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_w = 1'b0;
    end else if (bus.branch_taken_EX) begin
      // The ID instruction is squashed, so any load-use on it is moot.
      ifid_f  = 1'b1;
      idex_f  = 1'b1;
    end else if (load_use) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_f  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      wait_cnt  <= 8'd0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_w)  stall_cnt <= sat_inc(stall_cnt);
      if (ifid_f) flush_cnt <= sat_inc(flush_cnt);

      case (state)
        ST_RUN: begin
          if (mem_miss) begin
            if (MEM_TIMEOUT == 1) begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end else begin
              state    <= ST_MEM_WAIT;
              wait_cnt <= 8'd1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_miss) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
          end else if (({1'b0, wait_cnt} + 9'd1) == TIMEOUT_LIM) begin
            state <= ST_ERROR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign bus.PC_write        = pc_w;
  assign bus.IF_ID_write     = ifid_w;
  assign bus.IF_ID_flush     = ifid_f;
  assign bus.ID_EX_write     = idex_w;
  assign bus.ID_EX_flush     = idex_f;
  assign bus.EX_MEM_write    = exmem_w;
  assign bus.MEM_WB_write    = memwb_w;
  assign bus.mem_timeout_err = err;
  assign bus.stall_cnt       = stall_cnt;
  assign bus.flush_cnt       = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MEM_TIMEOUT=4.
// Enable vector order: {PC_w, IF_ID_w, IF_ID_f, ID_EX_w, ID_EX_f, EX_MEM_w, MEM_WB_w}
module tb_hazard_stall_ctrl;

  localparam logic [6:0] EN_RUN = 7'b1101011;
  localparam logic [6:0] EN_LU  = 7'b0001111;
  localparam logic [6:0] EN_BR  = 7'b1111111;
  localparam logic [6:0] EN_FRZ = 7'b0000000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] en;

  hazard_stall_ctrl_if #(.CNT_W(32)) bus ();

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign en = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
               bus.ID_EX_flush, bus.EX_MEM_write, bus.MEM_WB_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic br, input logic req, input logic rdy);
    bus.MemRead_EX      = mr;
    bus.RD_EX           = rd;
    bus.RS1_ID          = rs1;
    bus.RS2_ID          = rs2;
    bus.uses_rs1_ID     = u1;
    bus.uses_rs2_ID     = u2;
    bus.branch_taken_EX = br;
    bus.mem_req_MEM     = req;
    bus.mem_ready       = rdy;
  endtask

  // One cycle: drive at negedge, check enables mid-cycle, step past posedge.
  task automatic apply(input string tag, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic br,
                       input logic req, input logic rdy, input logic [6:0] exp_en);
    @(negedge clk);
    set_in(mr, rd, rs1, rs2, u1, u2, br, req, rdy);
    #1;
    chk(tag, 32'(en), 32'(exp_en));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    apply(tag, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, EN_RUN);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk({tag, "_err"},   32'(bus.mem_timeout_err), 32'd0);
    chk({tag, "_stall"}, bus.stall_cnt, 32'd0);
    chk({tag, "_flush"}, bus.flush_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    // Even a memory miss must not freeze anything while reset is held.
    @(negedge clk);
    set_in(1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0);
    #1;
    chk("rst_en", 32'(en), 32'(EN_RUN));
    @(posedge clk);
    #1;
    chk("rst_err",   32'(bus.mem_timeout_err), 32'd0);
    chk("rst_stall", bus.stall_cnt, 32'd0);
    chk("rst_flush", bus.flush_cnt, 32'd0);
    do_reset("rst2");

    // Load-use and its suppressions
    apply("lu_rs1",     1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, EN_LU);
    chk("lu_stall1", bus.stall_cnt, 32'd1);
    chk("lu_flush0", bus.flush_cnt, 32'd0);
    apply("lu_rd0",     1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, EN_RUN);
    apply("lu_nouse",   1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, EN_RUN);
    apply("lu_noload",  0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, EN_RUN);
    chk("lu_stall_hold", bus.stall_cnt, 32'd1);
    apply("lu_rs2",     1, 5'd7, 5'd3, 5'd7, 1, 1, 0, 0, 0, EN_LU);
    chk("lu_stall2", bus.stall_cnt, 32'd2);

    // Branch overrides load-use; same-cycle ready causes no stall
    do_reset("rst_br");
    apply("br_lu",      1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, EN_BR);
    chk("br_flush1", bus.flush_cnt, 32'd1);
    chk("br_stall0", bus.stall_cnt, 32'd0);
    apply("hit_now",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, EN_RUN);
    apply("rdy_noreq",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, EN_RUN);
    chk("hit_stall0", bus.stall_cnt, 32'd0);

    // Memory wait of 3 cycles, released on ready
    do_reset("rst_mw");
    for (int i = 0; i < 3; i++)
      apply($sformatf("mw_frz%0d", i), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, EN_FRZ);
    chk("mw_stall3", bus.stall_cnt, 32'd3);
    apply("mw_release", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, EN_RUN);
    chk("mw_stall_hold", bus.stall_cnt, 32'd3);
    chk("mw_err0", 32'(bus.mem_timeout_err), 32'd0);
    // A fresh 3-cycle wait must not time out if the wait count was cleared.
    for (int i = 0; i < 3; i++)
      apply($sformatf("mw2_frz%0d", i), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, EN_FRZ);
    apply("mw2_release", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, EN_RUN);
    chk("mw2_err0", 32'(bus.mem_timeout_err), 32'd0);
    chk("mw2_stall6", bus.stall_cnt, 32'd6);
    apply("mw2_lu",     1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, 0, EN_LU);

    // Timeout after 4 miss cycles, sticky until reset
    do_reset("rst_to");
    for (int i = 0; i < 3; i++)
      apply($sformatf("to_frz%0d", i), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, EN_FRZ);
    chk("to_err_early", 32'(bus.mem_timeout_err), 32'd0);
    apply("to_frz3",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, EN_FRZ);
    chk("to_err1", 32'(bus.mem_timeout_err), 32'd1);
    chk("to_stall4", bus.stall_cnt, 32'd4);
    apply("to_err_rdy", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, EN_FRZ);
    apply("to_err_idle", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, EN_FRZ);
    chk("to_stall6", bus.stall_cnt, 32'd6);
    chk("to_flush0", bus.flush_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    #1;
    chk("to_rst_en", 32'(en), 32'(EN_RUN));
    @(posedge clk);
    #1;
    chk("to_rst_err",   32'(bus.mem_timeout_err), 32'd0);
    chk("to_rst_stall", bus.stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle("to_post_idle");

    // Miss together with branch and load-use: freeze first, then flush
    do_reset("rst_sim");
    apply("sim_frz",    1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0, EN_FRZ);
    chk("sim_flush0", bus.flush_cnt, 32'd0);
    chk("sim_stall1", bus.stall_cnt, 32'd1);
    apply("sim_rel",    1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 1, EN_BR);
    chk("sim_flush1", bus.flush_cnt, 32'd1);
    chk("sim_stall_hold", bus.stall_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
